// File: rtl/hdlc_rx_deframer_pkg.sv
// ---------------------------------------------------------------------------
// hdlc_pkg
// Shared constants and types for the HDLC receive deframer.
//   FLAG_PATTERN : opening/closing flag byte (0x7E)
//   ABORT_ONES   : run of consecutive ones that marks an abort
//   STUFF_ONES   : run of ones after which a following zero is a stuff bit
//   rx_state_t   : deframer frame state (IDLE / INFRAME)
//   satInc       : saturating increment used by the ones counter
// ---------------------------------------------------------------------------
package hdlc_pkg;

    localparam logic [7:0] FLAG_PATTERN = 8'h7E;
    localparam int         ABORT_ONES   = 7;
    localparam int         STUFF_ONES   = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        INFRAME = 1'b1
    } rx_state_t;

    // Increment, holding at limit once it is reached.
    function automatic logic [2:0] satInc(input logic [2:0] value, input logic [2:0] limit);
        return (value >= limit) ? limit : value + 3'd1;
    endfunction

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// ---------------------------------------------------------------------------
// hdlc_rx_deframer_if
// Serial input and byte/status output bundle of the HDLC receive deframer.
//   RxEN, Rx         : bit enable and serial line (line side -> deframer)
//   Rx_Data          : assembled byte, first received bit in bit 0
//   Rx_NewByte       : one-cycle strobe, Rx_Data valid
//   Rx_ValidFrame    : level, high while inside a frame
//   Rx_FlagDetect    : one-cycle strobe per detected flag
//   Rx_AbortDetect   : one-cycle strobe on abort inside a frame
//   Rx_EoF           : one-cycle strobe, frame closed correctly
//   Rx_FrameError    : one-cycle strobe, closing flag not byte aligned
// Modports: master = line/consumer side, slave = deframer.
// ---------------------------------------------------------------------------
interface hdlc_rx_deframer_if;

    logic       RxEN;
    logic       Rx;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte;
    logic       Rx_ValidFrame;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_EoF;
    logic       Rx_FrameError;

    modport master (
        output RxEN,
        output Rx,
        input  Rx_Data,
        input  Rx_NewByte,
        input  Rx_ValidFrame,
        input  Rx_FlagDetect,
        input  Rx_AbortDetect,
        input  Rx_EoF,
        input  Rx_FrameError
    );

    modport slave (
        input  RxEN,
        input  Rx,
        output Rx_Data,
        output Rx_NewByte,
        output Rx_ValidFrame,
        output Rx_FlagDetect,
        output Rx_AbortDetect,
        output Rx_EoF,
        output Rx_FrameError
    );

endinterface

// File: rtl/hdlc_rx_deframer_destuff.sv
// ---------------------------------------------------------------------------
// hdlc_rx_destuff
// Zero-bit removal for the HDLC receive data path. Counts consecutive ones
// among valid bits (saturating) and suppresses a zero that follows exactly
// STUFF_ONES ones.
//   Clk, Rst      : clock, synchronous active-low reset
//   clear         : zero the ones counter (flag or abort seen)
//   bit_in        : candidate data bit
//   bit_valid     : bit_in is a real data bit this cycle
//   bit_out       : data bit forwarded to the byte assembler
//   bit_out_valid : bit_out is to be accepted (stuff zeros are dropped)
// ---------------------------------------------------------------------------
module hdlc_rx_destuff #(
    parameter int STUFF_ONES = hdlc_pkg::STUFF_ONES,
    parameter int SAT_ONES   = hdlc_pkg::ABORT_ONES - 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic bit_in,
    input  logic bit_valid,
    output logic bit_out,
    output logic bit_out_valid
);
    import hdlc_pkg::*;

    localparam logic [2:0] STUFF_LIMIT = 3'(STUFF_ONES);
    localparam logic [2:0] SAT_LIMIT   = 3'(SAT_ONES);

    logic [2:0] onesReg;
    logic [2:0] onesNext;
    logic       dropBit;

    assign dropBit       = bit_valid && !bit_in && (onesReg == STUFF_LIMIT);
    assign bit_out       = bit_in;
    assign bit_out_valid = bit_valid && !dropBit;

    always_comb begin
        onesNext = onesReg;
        if (bit_valid) begin
            // A dropped stuff zero and an ordinary zero both restart the run.
            onesNext = bit_in ? satInc(onesReg, SAT_LIMIT) : 3'd0;
        end
        if (clear) begin
            onesNext = 3'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            onesReg <= 3'd0;
        end else begin
            onesReg <= onesNext;
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// ---------------------------------------------------------------------------
// hdlc_rx_deframer
// Bit-level HDLC receive front end: flag/abort detection on an 8-bit raw
// window, zero destuffing of the bits leaving the window, LSB-first byte
// assembly and frame status strobes.
//   Clk  : clock, all logic on the rising edge
//   Rst  : synchronous active-low reset
//   rxIf : slave side of hdlc_rx_deframer_if (RxEN/Rx in, byte + status out)
// Raw bits enter window[7]; the bit leaving window[0] is the delayed bit fed
// to the data path. A valid mask travels with the window so that flag bits
// (mask cleared on flag) never reach the data path.
// ---------------------------------------------------------------------------
module hdlc_rx_deframer #(
    parameter logic [7:0] FLAG_PATTERN = hdlc_pkg::FLAG_PATTERN,
    parameter int         ABORT_ONES   = hdlc_pkg::ABORT_ONES,
    parameter int         STUFF_ONES   = hdlc_pkg::STUFF_ONES
) (
    input  logic               Clk,
    input  logic               Rst,
    hdlc_rx_deframer_if.slave  rxIf
);
    import hdlc_pkg::*;

    rx_state_t  stateReg,     stateNext;
    logic [7:0] windowReg,    windowNext;
    logic [7:0] maskReg,      maskNext;
    logic [7:0] dataShiftReg, dataShiftNext;
    logic [2:0] bitCountReg,  bitCountNext;
    logic       byteSeenReg,  byteSeenNext;
    logic [7:0] rxDataReg,    rxDataNext;
    logic       newByteReg,   newByteNext;
    logic       flagReg,      flagNext;
    logic       abortReg,     abortNext;
    logic       eofReg,       eofNext;
    logic       frameErrReg,  frameErrNext;

    logic [7:0]            shiftedWindow;
    logic [ABORT_ONES-1:0] abortTaps;
    logic                  delayedValid;
    logic                  destuffBit;
    logic                  destuffValid;
    logic                  flagHit;
    logic                  abortHit;
    logic [7:0]            acceptedShift;
    logic [2:0]            bitCountAfter;
    logic                  byteDone;
    logic                  byteSeenAfter;

    assign shiftedWindow = {rxIf.Rx, windowReg[7:1]};

    // The newest ABORT_ONES bits sit at the top of the post-shift window.
    for (genvar gi = 0; gi < ABORT_ONES; gi++) begin : gAbortTap
        assign abortTaps[gi] = shiftedWindow[7 - gi];
    end

    // Only bits inside a frame feed the data path.
    assign delayedValid = rxIf.RxEN && maskReg[0] && (stateReg == INFRAME);
    assign flagHit      = rxIf.RxEN && (shiftedWindow == FLAG_PATTERN);
    assign abortHit     = rxIf.RxEN && (stateReg == INFRAME) && (&abortTaps) && !flagHit;

    hdlc_rx_destuff #(
        .STUFF_ONES (STUFF_ONES),
        .SAT_ONES   (ABORT_ONES - 1)
    ) destuff (
        .Clk           (Clk),
        .Rst           (Rst),
        .clear         (flagHit || abortHit),
        .bit_in        (windowReg[0]),
        .bit_valid     (delayedValid),
        .bit_out       (destuffBit),
        .bit_out_valid (destuffValid)
    );

    // Data-path view after consuming the delayed bit; the flag decision on
    // the same edge is made against these values.
    assign acceptedShift = {destuffBit, dataShiftReg[7:1]};
    assign byteDone      = destuffValid && (bitCountReg == 3'd7);
    assign bitCountAfter = destuffValid ? bitCountReg + 3'd1 : bitCountReg;
    assign byteSeenAfter = byteSeenReg || byteDone;

    always_comb begin
        stateNext     = stateReg;
        windowNext    = windowReg;
        maskNext      = maskReg;
        dataShiftNext = dataShiftReg;
        bitCountNext  = bitCountReg;
        byteSeenNext  = byteSeenReg;
        rxDataNext    = rxDataReg;
        newByteNext   = 1'b0;
        flagNext      = 1'b0;
        abortNext     = 1'b0;
        eofNext       = 1'b0;
        frameErrNext  = 1'b0;

        if (rxIf.RxEN) begin
            windowNext = shiftedWindow;
            maskNext   = {1'b1, maskReg[7:1]};

            if (destuffValid) begin
                dataShiftNext = acceptedShift;
                bitCountNext  = bitCountAfter;
            end
            if (byteDone) begin
                rxDataNext   = acceptedShift;
                newByteNext  = 1'b1;
                byteSeenNext = 1'b1;
            end

            if (flagHit) begin
                flagNext     = 1'b1;
                maskNext     = 8'h00;
                bitCountNext = 3'd0;
                byteSeenNext = 1'b0;
                if (stateReg == IDLE) begin
                    stateNext = INFRAME;
                end else if (bitCountAfter != 3'd0) begin
                    frameErrNext = 1'b1;
                end else if (byteSeenAfter) begin
                    // Closing flag; it may also open the next frame, so
                    // the state stays INFRAME.
                    eofNext = 1'b1;
                end
            end else if (abortHit) begin
                abortNext    = 1'b1;
                stateNext    = IDLE;
                maskNext     = 8'h00;
                bitCountNext = 3'd0;
                byteSeenNext = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stateReg     <= IDLE;
            windowReg    <= 8'hFF;
            maskReg      <= 8'h00;
            dataShiftReg <= 8'h00;
            bitCountReg  <= 3'd0;
            byteSeenReg  <= 1'b0;
            rxDataReg    <= 8'h00;
            newByteReg   <= 1'b0;
            flagReg      <= 1'b0;
            abortReg     <= 1'b0;
            eofReg       <= 1'b0;
            frameErrReg  <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            windowReg    <= windowNext;
            maskReg      <= maskNext;
            dataShiftReg <= dataShiftNext;
            bitCountReg  <= bitCountNext;
            byteSeenReg  <= byteSeenNext;
            rxDataReg    <= rxDataNext;
            newByteReg   <= newByteNext;
            flagReg      <= flagNext;
            abortReg     <= abortNext;
            eofReg       <= eofNext;
            frameErrReg  <= frameErrNext;
        end
    end

    assign rxIf.Rx_Data        = rxDataReg;
    assign rxIf.Rx_NewByte     = newByteReg;
    assign rxIf.Rx_ValidFrame  = (stateReg == INFRAME);
    assign rxIf.Rx_FlagDetect  = flagReg;
    assign rxIf.Rx_AbortDetect = abortReg;
    assign rxIf.Rx_EoF         = eofReg;
    assign rxIf.Rx_FrameError  = frameErrReg;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_hdlc_rx_deframer
// Directed bench for hdlc_rx_deframer: serial bit sequences with hand-worked
// expected strobe counts and byte values.
// ---------------------------------------------------------------------------
module tb_hdlc_rx_deframer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hdlc_rx_deframer_if rxIf ();

    hdlc_rx_deframer dut (
        .Clk  (clk),
        .Rst  (rst),
        .rxIf (rxIf.slave)
    );

    int total = 0;
    int bad   = 0;

    int flagCnt;
    int newByteCnt;
    int abortCnt;
    int eofCnt;
    int errCnt;
    int eofWithByte;
    int idleStrobes;
    logic [7:0] lastData;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic clearCounts();
        flagCnt     = 0;
        newByteCnt  = 0;
        abortCnt    = 0;
        eofCnt      = 0;
        errCnt      = 0;
        eofWithByte = 0;
        idleStrobes = 0;
        lastData    = 8'h00;
    endtask

    task automatic sampleOutputs();
        if (rxIf.Rx_FlagDetect)  flagCnt++;
        if (rxIf.Rx_AbortDetect) abortCnt++;
        if (rxIf.Rx_EoF)         eofCnt++;
        if (rxIf.Rx_FrameError)  errCnt++;
        if (rxIf.Rx_NewByte) begin
            newByteCnt++;
            lastData = rxIf.Rx_Data;
        end
        if (rxIf.Rx_NewByte && rxIf.Rx_EoF) eofWithByte++;
    endtask

    task automatic sendBit(input logic b);
        rxIf.Rx   = b;
        rxIf.RxEN = 1'b1;
        @(posedge clk);
        #1;
        sampleOutputs();
    endtask

    task automatic sendByte(input logic [7:0] value);
        for (int i = 0; i < 8; i++) sendBit(value[i]);
    endtask

    task automatic idleCycle();
        rxIf.RxEN = 1'b0;
        rxIf.Rx   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (rxIf.Rx_NewByte || rxIf.Rx_FlagDetect || rxIf.Rx_AbortDetect ||
            rxIf.Rx_EoF || rxIf.Rx_FrameError) idleStrobes++;
    endtask

    initial begin
        logic [7:0] partial;

        rxIf.RxEN = 1'b0;
        rxIf.Rx   = 1'b0;
        rst       = 1'b0;
        clearCounts();

        // Reset held for two edges with the line toggling.
        for (int i = 0; i < 2; i++) begin
            rxIf.RxEN = 1'b1;
            rxIf.Rx   = 1'(i);
            @(posedge clk);
            #1;
        end
        check("rst data",       rxIf.Rx_Data,        8'h00);
        check("rst newbyte",    rxIf.Rx_NewByte,     1'b0);
        check("rst validframe", rxIf.Rx_ValidFrame,  1'b0);
        check("rst flag",       rxIf.Rx_FlagDetect,  1'b0);
        check("rst abort",      rxIf.Rx_AbortDetect, 1'b0);
        check("rst eof",        rxIf.Rx_EoF,         1'b0);
        check("rst frameerr",   rxIf.Rx_FrameError,  1'b0);
        rst = 1'b1;

        // Flag, 0xA5, flag: last data bit leaves on the closing-flag edge.
        clearCounts();
        sendByte(8'h7E);
        check("a5 open flag",   flagCnt, 1);
        check("a5 validframe",  rxIf.Rx_ValidFrame, 1'b1);
        sendByte(8'hA5);
        sendByte(8'h7E);
        check("a5 flags",       flagCnt, 2);
        check("a5 newbytes",    newByteCnt, 1);
        check("a5 data",        lastData, 8'hA5);
        check("a5 eof",         eofCnt, 1);
        check("a5 eof+byte",    eofWithByte, 1);
        check("a5 frameerr",    errCnt, 0);

        // Flag, 0xFF stuffed as 11111 0 111, flag.
        clearCounts();
        sendByte(8'h7E);
        sendByte(8'h1F);            // 1,1,1,1,1,0,0,0 -> five ones, stuff zero, ...
        partial = 8'h00;            // overwritten below; keeps the bit list explicit
        // The byte above sent 1,1,1,1,1,0,0,0; restart that frame cleanly.
        sendByte(8'h7E);
        clearCounts();
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
        sendByte(8'h7E);
        check("ff newbytes",    newByteCnt, 1);
        check("ff data",        lastData, 8'hFF);
        check("ff abort",       abortCnt, 0);
        check("ff eof",         eofCnt, 1);
        check("ff frameerr",    errCnt, 0);

        // Flag, 0x3C, two zeros, seven ones: byte emitted, then abort.
        clearCounts();
        sendByte(8'h7E);
        sendByte(8'h3C);
        sendBit(1'b0);
        sendBit(1'b0);
        for (int i = 0; i < 7; i++) sendBit(1'b1);
        check("ab newbytes",    newByteCnt, 1);
        check("ab data",        lastData, 8'h3C);
        check("ab abort",       abortCnt, 1);
        check("ab validframe",  rxIf.Rx_ValidFrame, 1'b0);
        check("ab eof",         eofCnt, 0);

        // Flag, 12 data bits, flag: misaligned close.
        clearCounts();
        sendByte(8'h7E);
        sendByte(8'h5A);
        partial = 8'h04;            // 0,0,1,0
        for (int i = 0; i < 4; i++) sendBit(partial[i]);
        sendByte(8'h7E);
        check("fe flags",       flagCnt, 2);
        check("fe newbytes",    newByteCnt, 1);
        check("fe data",        lastData, 8'h5A);
        check("fe frameerr",    errCnt, 1);
        check("fe eof",         eofCnt, 0);
        check("fe validframe",  rxIf.Rx_ValidFrame, 1'b1);

        // Three idle flags, then 0x81 with RxEN low for three cycles mid-byte.
        clearCounts();
        sendByte(8'h7E);
        sendByte(8'h7E);
        sendByte(8'h7E);
        check("id idle eof",    eofCnt, 0);
        partial = 8'h81;
        for (int i = 0; i < 4; i++) sendBit(partial[i]);
        idleCycle();
        idleCycle();
        idleCycle();
        for (int i = 4; i < 8; i++) sendBit(partial[i]);
        sendByte(8'h7E);
        check("id flags",       flagCnt, 4);
        check("id idlestrobes", idleStrobes, 0);
        check("id newbytes",    newByteCnt, 1);
        check("id data",        lastData, 8'h81);
        check("id eof",         eofCnt, 1);
        check("id frameerr",    errCnt, 0);

        // Reset mid-frame: partial byte lost, no strobes, back to IDLE.
        clearCounts();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        rst = 1'b0;
        rxIf.RxEN = 1'b1;
        @(posedge clk);
        #1;
        sampleOutputs();
        check("mr validframe",  rxIf.Rx_ValidFrame, 1'b0);
        check("mr data",        rxIf.Rx_Data, 8'h00);
        check("mr newbytes",    newByteCnt, 0);
        rst = 1'b1;

        // Recovery after reset.
        clearCounts();
        sendByte(8'h7E);
        sendByte(8'h42);
        sendByte(8'h7E);
        check("rc newbytes",    newByteCnt, 1);
        check("rc data",        lastData, 8'h42);
        check("rc eof",         eofCnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
